pulsed_write_driver: RTL and testbench

PULSED_WRITE_DRIVER -- requirements
Module: pulsed_write_driver

---
 rtl/pulsed_write_driver.sv | 200 ++++++++++++++++++++
 tb/tb_pulsed_write_driver.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulsed_write_driver.sv
// ---------------------------------------------------------------------------
// pulsed_write_driver
//
// Drives the bitline pairs of one SRAM row for a masked word write. Each
// accepted request steps through a timed sequence:
//   IDLE -> PRECHARGE (PRE_CYCLES) -> DRIVE (latched pulse length) ->
//   RECOVER (1 cycle, done pulse) -> IDLE
// A request whose word address is out of range is rejected with a one-cycle
// err pulse, and nothing is driven.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   req_valid    : write request present
//   req_ready    : high only in IDLE; acceptance = req_valid && req_ready
//   col_addr     : word (column group) address, AW bits
//   data_in      : write data, WORD_SIZE bits
//   bit_mask     : per-bit write enable (1 = drive this bit)
//   pulse_len    : DRIVE length in cycles (0 is treated as 1)
//   bitline      : BL level per column
//   bitline_bar  : BLB level per column
//   bl_oe        : driver enable per column
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse in RECOVER
//   err          : one-cycle pulse after an out-of-range request
//   dbg_state    : current FSM state (0 IDLE, 1 PRECHARGE, 2 DRIVE, 3 RECOVER)
//
// Handshake: req_valid/req_ready follow strict valid/ready semantics. A
// request transfers on a rising edge where both are high; req_ready depends
// only on registered state, never on req_valid. Inputs are ignored while busy.
// ---------------------------------------------------------------------------
module pulsed_write_driver #(
  parameter int WORD_SIZE  = 4,
  parameter int NUM_WORDS  = 16,
  parameter int NUM_COLS   = WORD_SIZE * NUM_WORDS,
  parameter int PRE_CYCLES = 1,
  parameter int PW         = 4,
  parameter int AW         = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AW-1:0]        col_addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] bit_mask,
  input  logic [PW-1:0]        pulse_len,
  output logic [NUM_COLS-1:0]  bitline,
  output logic [NUM_COLS-1:0]  bitline_bar,
  output logic [NUM_COLS-1:0]  bl_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  // The phase counter has to hold both PRE_CYCLES-1 and a full pulse length.
  localparam int PRE_BITS = $clog2(PRE_CYCLES) + 1;
  localparam int CW       = (PW > PRE_BITS) ? PW : PRE_BITS;

  // AW+1 bits always hold NUM_WORDS, so the range check needs no truncation.
  localparam logic [AW:0] LP_NUM_WORDS = (AW + 1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRECHARGE = 2'd1,
    S_DRIVE     = 2'd2,
    S_RECOVER   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;

  logic [AW-1:0]        r_addr;
  logic [WORD_SIZE-1:0] r_data;
  logic [WORD_SIZE-1:0] r_mask;
  logic [PW-1:0]        r_len;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_addr_ok;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_addr_ok = ({1'b0, col_addr} < LP_NUM_WORDS);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. r_cnt counts down the remaining cycles of the current
  // timed phase; the phase ends in the cycle where it reads zero.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_addr_ok) begin
          w_state_nxt = S_PRECHARGE;
          w_cnt_nxt   = CW'(PRE_CYCLES - 1);
        end
      end
      S_PRECHARGE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = CW'(r_len) - CW'(1);
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_RECOVER: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latches and error pulse. The latches only load on a legal
  // acceptance, so the request stays frozen for the whole sequence.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_mask <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && !w_addr_ok;
      if (w_accept && w_addr_ok) begin
        r_addr <= col_addr;
        r_data <= data_in;
        r_mask <= bit_mask;
        r_len  <= (pulse_len == '0) ? PW'(1) : pulse_len;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state and latches only.
  // Undriven columns always float at 1/1, and a driven column always gets
  // complementary levels, so BL and BLB can never both be low.
  // -------------------------------------------------------------------------
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_RECOVER);
  assign err       = r_err;
  assign dbg_state = r_state;

  always_comb begin
    bitline     = '1;
    bitline_bar = '1;
    bl_oe       = '0;
    case (r_state)
      S_PRECHARGE, S_RECOVER: begin
        bl_oe = '1;
      end
      S_DRIVE: begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          for (int b = 0; b < WORD_SIZE; b++) begin
            if ((w * WORD_SIZE + b) < NUM_COLS) begin
              if ((r_addr == AW'(w)) && r_mask[b]) begin
                bl_oe[w * WORD_SIZE + b]       = 1'b1;
                bitline[w * WORD_SIZE + b]     = r_data[b];
                bitline_bar[w * WORD_SIZE + b] = ~r_data[b];
              end
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pulsed_write_driver.sv
// ---------------------------------------------------------------------------
// tb_pulsed_write_driver
//
// Directed bench for pulsed_write_driver. The main instance uses the default
// parameters (4-bit words, 16 words, 64 columns). A second, small instance
// (2-bit words, 3 words, AW=2) makes an out-of-range address reachable so
// the rejection path can be exercised.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pulsed_write_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main instance signals ----------------
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  col_addr;
  logic [3:0]  data_in;
  logic [3:0]  bit_mask;
  logic [3:0]  pulse_len;
  logic [63:0] bitline;
  logic [63:0] bitline_bar;
  logic [63:0] bl_oe;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  // ---------------- small instance signals ----------------
  logic        e_req_valid;
  logic        e_req_ready;
  logic [1:0]  e_col_addr;
  logic [1:0]  e_data_in;
  logic [1:0]  e_bit_mask;
  logic [3:0]  e_pulse_len;
  logic [5:0]  e_bitline;
  logic [5:0]  e_bitline_bar;
  logic [5:0]  e_bl_oe;
  logic        e_busy;
  logic        e_done;
  logic        e_err;
  logic [1:0]  e_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  pulsed_write_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .col_addr   (col_addr),
    .data_in    (data_in),
    .bit_mask   (bit_mask),
    .pulse_len  (pulse_len),
    .bitline    (bitline),
    .bitline_bar(bitline_bar),
    .bl_oe      (bl_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  pulsed_write_driver #(
    .WORD_SIZE(2),
    .NUM_WORDS(3)
  ) dut_e (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (e_req_valid),
    .req_ready  (e_req_ready),
    .col_addr   (e_col_addr),
    .data_in    (e_data_in),
    .bit_mask   (e_bit_mask),
    .pulse_len  (e_pulse_len),
    .bitline    (e_bitline),
    .bitline_bar(e_bitline_bar),
    .bl_oe      (e_bl_oe),
    .busy       (e_busy),
    .done       (e_done),
    .err        (e_err),
    .dbg_state  (e_dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle outputs of the main instance.
  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    chk({tag, ".busy"},  64'(busy),      64'd0);
    chk({tag, ".done"},  64'(done),      64'd0);
    chk({tag, ".oe"},    bl_oe,          64'h0);
    chk({tag, ".bl"},    bitline,        '1);
    chk({tag, ".blb"},   bitline_bar,    '1);
  endtask

  // Precharge / recover outputs of the main instance.
  task automatic chk_pre(input string tag, input logic exp_done);
    chk({tag, ".ready"}, 64'(req_ready), 64'd0);
    chk({tag, ".busy"},  64'(busy),      64'd1);
    chk({tag, ".done"},  64'(done),      64'(exp_done));
    chk({tag, ".oe"},    bl_oe,          '1);
    chk({tag, ".bl"},    bitline,        '1);
    chk({tag, ".blb"},   bitline_bar,    '1);
  endtask

  task automatic chk_drive(input string tag, input logic [63:0] e_oe,
                           input logic [63:0] e_bl, input logic [63:0] e_blb);
    chk({tag, ".state"}, 64'(dbg_state), 64'd2);
    chk({tag, ".done"},  64'(done),      64'd0);
    chk({tag, ".oe"},    bl_oe,          e_oe);
    chk({tag, ".bl"},    bitline,        e_bl);
    chk({tag, ".blb"},   bitline_bar,    e_blb);
  endtask

  // Issue one request and measure busy/DRIVE/done cycle counts (bounded).
  task automatic run_len(input string tag, input logic [3:0] len,
                         input int exp_busy, input int exp_drive);
    int nb;
    int nd;
    int ndone;
    col_addr  = 4'd2;
    data_in   = 4'b1001;
    bit_mask  = 4'hF;
    pulse_len = len;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    nb = 0;
    nd = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      if (dbg_state == 2'd2) nd++;
      if (done) ndone++;
      tick();
    end
    chk({tag, ".busy_cycles"},  64'(nb),    64'(exp_busy));
    chk({tag, ".drive_cycles"}, 64'(nd),    64'(exp_drive));
    chk({tag, ".done_pulses"},  64'(ndone), 64'd1);
    chk({tag, ".ended_idle"},   64'(busy),  64'd0);
  endtask

  // BL and BLB must never both be low on any column, checked every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("no_short", ~bitline & ~bitline_bar, 64'h0);
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    col_addr    = '0;
    data_in     = '0;
    bit_mask    = '0;
    pulse_len   = '0;
    e_req_valid = 1'b0;
    e_col_addr  = '0;
    e_data_in   = '0;
    e_bit_mask  = '0;
    e_pulse_len = '0;

    // Reset state
    #12;
    chk_idle("reset");
    chk("reset.err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Basic write: word 3, data 1010, full mask, pulse_len 2
    col_addr  = 4'd3;
    data_in   = 4'b1010;
    bit_mask  = 4'hF;
    pulse_len = 4'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_pre("basic.pre", 1'b0);
    tick();
    chk_drive("basic.drive1", 64'h0000_0000_0000_F000,
              64'hFFFF_FFFF_FFFF_AFFF, 64'hFFFF_FFFF_FFFF_5FFF);
    tick();
    chk_drive("basic.drive2", 64'h0000_0000_0000_F000,
              64'hFFFF_FFFF_FFFF_AFFF, 64'hFFFF_FFFF_FFFF_5FFF);
    tick();
    chk_pre("basic.recover", 1'b1);
    chk("basic.recover_state", 64'(dbg_state), 64'd3);
    tick();
    chk_idle("basic.idle");

    // Masking: word 0, data 0000, mask 0101
    col_addr  = 4'd0;
    data_in   = 4'b0000;
    bit_mask  = 4'b0101;
    pulse_len = 4'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_pre("mask.pre", 1'b0);
    tick();
    chk_drive("mask.drive", 64'h0000_0000_0000_0005,
              64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk_pre("mask.recover", 1'b1);
    tick();
    chk_idle("mask.idle");

    // Pulse length boundaries: 0 behaves as 1, 15 gives 15 DRIVE cycles
    run_len("len0", 4'd0, 3, 1);
    run_len("len15", 4'd15, 17, 15);

    // Zero mask: full sequence, nothing driven, done still pulses
    col_addr  = 4'd7;
    data_in   = 4'b0110;
    bit_mask  = 4'b0000;
    pulse_len = 4'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_pre("mask0.pre", 1'b0);
    tick();
    chk_drive("mask0.drive", 64'h0, '1, '1);
    tick();
    chk_pre("mask0.recover", 1'b1);
    tick();
    chk_idle("mask0.idle");

    // Valid held high with changing inputs while busy, then back-to-back.
    // Request A: word 5, data 0110, full mask, length 2.
    col_addr  = 4'd5;
    data_in   = 4'b0110;
    bit_mask  = 4'hF;
    pulse_len = 4'd2;
    req_valid = 1'b1;
    tick();
    chk_pre("hold.pre", 1'b0);
    col_addr  = 4'd9;
    data_in   = 4'b1111;
    bit_mask  = 4'b0001;
    pulse_len = 4'd7;
    tick();
    chk_drive("hold.drive1", 64'h0000_0000_00F0_0000,
              64'hFFFF_FFFF_FF6F_FFFF, 64'hFFFF_FFFF_FF9F_FFFF);
    col_addr  = 4'd0;
    data_in   = 4'b0000;
    bit_mask  = 4'b1000;
    pulse_len = 4'd0;
    tick();
    chk_drive("hold.drive2", 64'h0000_0000_00F0_0000,
              64'hFFFF_FFFF_FF6F_FFFF, 64'hFFFF_FFFF_FF9F_FFFF);
    // Request B waits on the inputs: word 1, data 1111, mask 0011, length 1
    col_addr  = 4'd1;
    data_in   = 4'b1111;
    bit_mask  = 4'b0011;
    pulse_len = 4'd1;
    tick();
    chk_pre("hold.recover", 1'b1);
    tick();
    // Exactly one IDLE cycle between done and the next PRECHARGE
    chk("b2b.idle_ready", 64'(req_ready), 64'd1);
    chk("b2b.idle_state", 64'(dbg_state), 64'd0);
    chk("b2b.idle_oe",    bl_oe,          64'h0);
    tick();
    req_valid = 1'b0;
    chk_pre("b2b.pre", 1'b0);
    chk("b2b.pre_state", 64'(dbg_state), 64'd1);
    tick();
    chk_drive("b2b.drive", 64'h0000_0000_0000_0030,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFCF);
    tick();
    chk_pre("b2b.recover", 1'b1);
    tick();
    chk_idle("b2b.idle");

    // Reset mid-DRIVE: outputs drop to idle without a clock edge
    col_addr  = 4'd4;
    data_in   = 4'b0011;
    bit_mask  = 4'hF;
    pulse_len = 4'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst.in_drive", 64'(dbg_state), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst.async");
    #1;
    rst_n = 1'b1;
    // New request is accepted on the first edge after release
    col_addr  = 4'd15;
    data_in   = 4'b0101;
    bit_mask  = 4'hF;
    pulse_len = 4'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_pre("rst.accept_pre", 1'b0);
    tick();
    chk_drive("rst.drive", 64'hF000_0000_0000_0000,
              64'h5FFF_FFFF_FFFF_FFFF, 64'hAFFF_FFFF_FFFF_FFFF);
    tick();
    chk_pre("rst.recover", 1'b1);
    tick();
    chk_idle("rst.idle");

    // Out-of-range address on the 3-word instance: err pulse, nothing driven
    e_col_addr  = 2'd3;
    e_data_in   = 2'b01;
    e_bit_mask  = 2'b11;
    e_pulse_len = 4'd2;
    e_req_valid = 1'b1;
    tick();
    e_req_valid = 1'b0;
    chk("err.pulse", 64'(e_err),       64'd1);
    chk("err.busy",  64'(e_busy),      64'd0);
    chk("err.ready", 64'(e_req_ready), 64'd1);
    chk("err.oe",    64'(e_bl_oe),     64'h0);
    tick();
    chk("err.clear", 64'(e_err),       64'd0);
    chk("err.state", 64'(e_dbg_state), 64'd0);

    // Highest legal word on the 3-word instance: columns 5:4 driven
    e_col_addr  = 2'd2;
    e_data_in   = 2'b10;
    e_bit_mask  = 2'b11;
    e_pulse_len = 4'd1;
    e_req_valid = 1'b1;
    tick();
    e_req_valid = 1'b0;
    chk("e.pre_oe", 64'(e_bl_oe), 64'h3F);
    chk("e.no_err", 64'(e_err),   64'd0);
    tick();
    chk("e.drive_oe",  64'(e_bl_oe),       64'h30);
    chk("e.drive_bl",  64'(e_bitline),     64'h2F);
    chk("e.drive_blb", 64'(e_bitline_bar), 64'h1F);
    tick();
    chk("e.done", 64'(e_done), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
